// File: rtl/sync_fa_bist_pkg.sv
// Shared types and constants for the full-adder BIST controller: FSM states,
// vector count, legal latency window and the expected-value pipeline entry.
package sync_fa_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int NUM_VECS    = 8;
    localparam int VEC_W       = 3;
    localparam int ERR_W       = 4;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 3;

    // One slot of the expected-response pipeline: the vector that was presented
    // and the golden response it must produce LATENCY cycles later.
    typedef struct packed {
        logic             valid;
        logic [VEC_W-1:0] vec;
        logic             exp_sum;
        logic             exp_cout;
    } exp_entry_t;

endpackage

// File: rtl/sync_fa_bist_fa_golden.sv
// Combinational reference full adder that produces the expected response
// for the vector currently being presented.
module fa_golden (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/sync_fa_bist.sv
// BIST controller for a registered full adder: drives all 8 input vectors,
// compares each response LATENCY cycles later and reports error statistics.
module sync_fa_bist
    import sync_fa_bist_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_cin,
    input  logic             dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail
);

    localparam logic [1:0]       DRAIN_LAST = 2'(LATENCY - 1);
    localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(NUM_VECS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = ERR_W'(NUM_VECS);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] stim_q, stim_d;
    logic [1:0]       drain_q, drain_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [VEC_W-1:0] first_fail_q, first_fail_d;

    exp_entry_t       pipe_q [LATENCY];
    exp_entry_t       pipe_in;
    exp_entry_t       pipe_out;
    logic             exp_sum;
    logic             exp_cout;
    logic             mismatch;

    fa_golden u_golden (
        .a_i    (stim_q[2]),
        .b_i    (stim_q[1]),
        .cin_i  (stim_q[0]),
        .sum_o  (exp_sum),
        .cout_o (exp_cout)
    );

    // Only DRIVE slots carry a real vector; DRAIN, IDLE and DONE push bubbles.
    assign pipe_in  = '{valid: (state_q == ST_DRIVE), vec: stim_q,
                        exp_sum: exp_sum, exp_cout: exp_cout};
    assign pipe_out = pipe_q[LATENCY-1];
    assign mismatch = pipe_out.valid &&
                      ((dut_sum != pipe_out.exp_sum) || (dut_cout != pipe_out.exp_cout));

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path can infer a latch.
        state_d      = state_q;
        stim_d       = '0;
        drain_d      = drain_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;

        if (mismatch) begin
            if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_W'(1);
            if (err_count_q == '0)      first_fail_d = pipe_out.vec;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_DRIVE;
                    err_count_d  = '0;
                    first_fail_d = '0;
                end
            end
            ST_DRIVE: begin
                if (stim_q == LAST_VEC) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    stim_d = stim_q + VEC_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = ST_DONE;
                else                       drain_d = drain_q + 2'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            stim_q       <= '0;
            drain_q      <= '0;
            err_count_q  <= '0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            stim_q       <= stim_d;
            drain_q      <= drain_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the pipeline is reset so stale valid bits from an aborted run are never compared.
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= pipe_in;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dut_a      = stim_q[2];
    assign dut_b      = stim_q[1];
    assign dut_cin    = stim_q[0];
    assign busy       = (state_q == ST_DRIVE) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign pass       = (state_q == ST_DONE) && (err_count_q == '0);
    assign err_count  = err_count_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_sync_fa_bist.sv
// Bench for sync_fa_bist: three controllers against behavioural FA models
// (matched and mismatched latency, injectable response faults), checked per cycle.
module tb_sync_fa_bist;

    localparam int NI     = 3;
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       start     = 1'b0;
    logic [7:0] sum_mask  = '0;
    logic [7:0] cout_mask = '0;

    logic       a_w [NI], b_w [NI], c_w [NI], sum_w [NI], cout_w [NI];
    logic       busy_w [NI], done_w [NI], pass_w [NI];
    logic [3:0] err_w [NI];
    logic [2:0] ff_w [NI];

    int n_pass   = 0;
    int n_total  = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: LATENCY=1 vs 1-stage FA with faults; 1: LATENCY=3 vs 3-stage FA;
    // 2: LATENCY=1 vs 3-stage FA (latency mismatch).
    sync_fa_bist #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a_w[0]), .dut_b(b_w[0]), .dut_cin(c_w[0]),
        .dut_sum(sum_w[0]), .dut_cout(cout_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .first_fail(ff_w[0])
    );
    sync_fa_bist #(.LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a_w[1]), .dut_b(b_w[1]), .dut_cin(c_w[1]),
        .dut_sum(sum_w[1]), .dut_cout(cout_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .first_fail(ff_w[1])
    );
    sync_fa_bist #(.LATENCY(1)) u_dut_slow (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a_w[2]), .dut_b(b_w[2]), .dut_cin(c_w[2]),
        .dut_sum(sum_w[2]), .dut_cout(cout_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err_w[2]), .first_fail(ff_w[2])
    );

    // Correct adder response as {cout, sum}: the plain arithmetic sum of the three bits.
    function automatic logic [1:0] fa_ref(input logic [2:0] v);
        return 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
    endfunction

    function automatic logic [1:0] faulty(input logic [2:0] v);
        return fa_ref(v) ^ {cout_mask[v], sum_mask[v]};
    endfunction

    logic [1:0] fa0_q = '0;
    logic [1:0] fa1_q [3] = '{default: '0};
    logic [1:0] fa2_q [3] = '{default: '0};

    always @(posedge clk) begin
        fa0_q    <= faulty({a_w[0], b_w[0], c_w[0]});
        fa1_q[0] <= fa_ref({a_w[1], b_w[1], c_w[1]});
        fa1_q[1] <= fa1_q[0];
        fa1_q[2] <= fa1_q[1];
        fa2_q[0] <= fa_ref({a_w[2], b_w[2], c_w[2]});
        fa2_q[1] <= fa2_q[0];
        fa2_q[2] <= fa2_q[1];
    end

    assign {cout_w[0], sum_w[0]} = fa0_q;
    assign {cout_w[1], sum_w[1]} = fa1_q[2];
    assign {cout_w[2], sum_w[2]} = fa2_q[2];

    function automatic int bist_lat(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic int fa_lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Which vectors of a run will miscompare. The response judged for vector v is
    // the one the FA produced for the stimulus presented v + LATENCY - FA_latency
    // slots into the run; outside the 8 vectors the controller presents 0.
    function automatic logic [7:0] predict_errors(input int i);
        logic [7:0] e;
        e = '0;
        for (int v = 0; v < 8; v++) begin
            int         s;
            logic [2:0] s3;
            logic [1:0] resp;
            s    = v + bist_lat(i) - fa_lat(i);
            s3   = (s >= 0 && s <= 7) ? 3'(s) : 3'd0;
            resp = (i == 0) ? faulty(s3) : fa_ref(s3);
            e[v] = (resp != fa_ref(3'(v)));
        end
        return e;
    endfunction

    int         m_phase [NI] = '{default: P_IDLE};
    int         m_k     [NI] = '{default: 0};
    logic [7:0] m_err   [NI] = '{default: '0};

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_phase[i] <= P_IDLE;
            end else if (m_phase[i] != P_RUN && start) begin
                m_phase[i] <= P_RUN;
                m_k[i]     <= 0;
                m_err[i]   <= predict_errors(i);
            end else if (m_phase[i] == P_RUN) begin
                if (m_k[i] == 7 + bist_lat(i)) m_phase[i] <= P_DONE;
                else                           m_k[i] <= m_k[i] + 1;
            end
        end
    end

    // Expected {busy, done, pass, a, b, cin, err_count, first_fail}. A mismatch on
    // vector v becomes visible LATENCY+1 cycles after v was presented.
    function automatic logic [12:0] expect_out(input int i);
        logic [3:0] cnt;
        logic [2:0] ff;
        logic       found;
        cnt   = '0;
        ff    = '0;
        found = 1'b0;
        for (int v = 0; v < 8; v++) begin
            if (m_err[i][v] && (m_phase[i] == P_DONE ||
                (m_phase[i] == P_RUN && v + bist_lat(i) + 1 <= m_k[i]))) begin
                cnt = cnt + 4'd1;
                if (!found) begin
                    ff    = 3'(v);
                    found = 1'b1;
                end
            end
        end
        case (m_phase[i])
            P_RUN:   return {3'b100, (m_k[i] < 8) ? 3'(m_k[i]) : 3'd0, cnt, ff};
            P_DONE:  return {2'b01, (cnt == 4'd0), 3'd0, cnt, ff};
            default: return '0;
        endcase
    endfunction

    function automatic logic [12:0] actual_out(input int i);
        return {busy_w[i], done_w[i], pass_w[i], a_w[i], b_w[i], c_w[i], err_w[i], ff_w[i]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < NI; i++) check($sformatf("cycle_out%0d", i), 32'(actual_out(i)), 32'(expect_out(i)));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse start, optionally re-pulse start or assert rst at run cycle k, and wait
    // (bounded) for every controller to reach DONE or for the reset to land.
    task automatic run(input int repulse_at, input int rst_at, output int busy0, output int busy1);
        bit finished;
        finished = 1'b0;
        busy0    = 0;
        busy1    = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 40 && !finished; k++) begin
            start = (k == repulse_at);
            rst   = (k == rst_at);
            @(negedge clk);
            if (busy_w[0]) busy0++;
            if (busy_w[1]) busy1++;
            if (done_w[0] && done_w[1] && done_w[2]) finished = 1'b1;
            if (rst_at >= 0 && k == rst_at + 1)      finished = 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst   = 1'b0;
        check("run_completes", 32'(finished), 32'd1);
    endtask

    initial begin
        int b0, b1, repulse, rst_at;
        repeat (3) @(posedge clk);
        #1 checking = 1'b1;
        rst = 1'b0;
        check("reset_state_l1", 32'(actual_out(0)), 32'd0);
        check("reset_state_l3", 32'(actual_out(1)), 32'd0);
        idle(3);

        run(-1, -1, b0, b1);
        check("clean_busy_l1", b0, 9);
        check("clean_busy_l3", b1, 11);
        check("clean_pass_l1", 32'(pass_w[0]), 1);
        check("clean_err_l1", 32'(err_w[0]), 0);
        check("clean_ff_l1", 32'(ff_w[0]), 0);
        check("clean_pass_l3", 32'(pass_w[1]), 1);
        check("latency_mismatch_pass", 32'(pass_w[2]), 0);

        idle(2);
        sum_mask = 8'b1001_0110;
        run(-1, -1, b0, b1);
        check("stuck_sum_err", 32'(err_w[0]), 4);
        check("stuck_sum_ff", 32'(ff_w[0]), 1);
        check("stuck_sum_pass", 32'(pass_w[0]), 0);

        idle(2);
        sum_mask  = 8'h00;
        cout_mask = 8'hFF;
        run(-1, -1, b0, b1);
        check("inv_cout_err", 32'(err_w[0]), 8);
        check("inv_cout_ff", 32'(ff_w[0]), 0);

        idle(2);
        cout_mask = 8'h00;
        run(3, -1, b0, b1);
        check("restart_busy_l1", b0, 9);
        check("restart_err_l1", 32'(err_w[0]), 0);
        check("restart_pass_l1", 32'(pass_w[0]), 1);

        run(-1, 4, b0, b1);
        check("mid_run_reset_l1", 32'(actual_out(0)), 32'd0);
        check("mid_run_reset_l3", 32'(actual_out(1)), 32'd0);

        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        check("rst_beats_start", 32'(busy_w[0]), 0);

        idle(2);
        run(-1, -1, b0, b1);
        check("post_reset_busy", b0, 9);
        check("post_reset_pass", 32'(pass_w[0]), 1);

        for (int it = 0; it < 16; it++) begin
            sum_mask  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cout_mask = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            rst_at    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1;
            repulse   = (rst_at < 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : -1;
            idle(int'($urandom_range(2, 5)));
            run(repulse, rst_at, b0, b1);
        end

        sum_mask  = 8'h00;
        cout_mask = 8'h00;
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
